// File: rtl/axis_memory_pkg.sv
// Shared defaults and types for the AXI-Stream scratch memory.
package axis_memory_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 12;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH         = DEFAULT_DATA_WIDTH / 8;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0]         strb_t;

endpackage

// File: rtl/axis_memory_ram.sv
// Simple dual-port byte-enabled RAM: one write port, one synchronous read port.
// A read of the address written on the same edge returns the old contents.
module axis_memory_ram #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_memory.sv
// Word-addressed RAM with AXIS-style write slave (s02) and single-beat read master (m02).
// Define AXIS_MEM_BYPASS_EN for write-first same-edge collisions; default is read-first.
module axis_memory
    import axis_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    s02_axis_aclk,
    input  logic                    s02_axis_aresetn,
    input  logic                    s02_axis_wr_en,
    input  logic [ADDR_WIDTH-1:0]   s02_axis_wr_addr,
    input  logic [DATA_WIDTH-1:0]   s02_axis_wr_tdata,
    input  logic [DATA_WIDTH/8-1:0] s02_axis_tstrb,
    input  logic                    s02_axis_tvalid,
    input  logic                    s02_axis_tlast,
    output logic                    s02_axis_tready,
    input  logic                    m02_axis_rd_en,
    input  logic [ADDR_WIDTH-1:0]   m02_axis_rd_addr,
    input  logic                    m02_axis_tready,
    output logic [DATA_WIDTH-1:0]   m02_axis_rd_tdata,
    output logic [DATA_WIDTH/8-1:0] m02_axis_tstrb,
    output logic                    m02_axis_tvalid,
    output logic                    m02_axis_tlast
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  s_tready_q, s_tready_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q,  m_tlast_d;
    logic [STRB_W-1:0]     m_tstrb_q,  m_tstrb_d;
    logic [DATA_WIDTH-1:0] hold_q,     hold_d;
    logic                  load_q,     load_d;
    logic                  wr_fire;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] fresh_data;
    logic                  unused_tlast;

    assign unused_tlast = s02_axis_tlast;

    axis_memory_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk     (s02_axis_aclk),
        .wr_en   (wr_fire),
        .wr_addr (s02_axis_wr_addr),
        .wr_data (s02_axis_wr_tdata),
        .wr_strb (s02_axis_tstrb),
        .rd_en   (rd_accept),
        .rd_addr (m02_axis_rd_addr),
        .rd_data (ram_rdata)
    );

`ifdef AXIS_MEM_BYPASS_EN
    logic                  byp_hit_q,  byp_hit_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic [STRB_W-1:0]     byp_strb_q, byp_strb_d;

    // Capture the colliding write so its strobed bytes override the RAM's read-first output.
    always_comb begin
        byp_hit_d  = wr_fire & rd_accept & (s02_axis_wr_addr == m02_axis_rd_addr);
        byp_data_d = s02_axis_wr_tdata;
        byp_strb_d = s02_axis_tstrb;
        fresh_data = ram_rdata;
        if (byp_hit_q) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (byp_strb_q[i]) begin
                    fresh_data[i*8 +: 8] = byp_data_q[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge s02_axis_aclk or negedge s02_axis_aresetn) begin
        if (!s02_axis_aresetn) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
            byp_strb_q <= '0;
        end else begin
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
            byp_strb_q <= byp_strb_d;
        end
    end
`else
    assign fresh_data = ram_rdata;
`endif

    always_comb begin
        s_tready_d = 1'b1;
        wr_fire    = s02_axis_wr_en & s02_axis_tvalid & s_tready_q;
        rd_accept  = m02_axis_rd_en & (~m_tvalid_q | m02_axis_tready);
        load_d     = rd_accept;
        // RAM output is only meaningful the cycle after an accept; latch it for stalls.
        hold_d     = load_q ? fresh_data : hold_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tstrb_d  = m_tstrb_q;
        if (rd_accept) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b1;
            m_tstrb_d  = '1;
        end else if (m02_axis_tready) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge s02_axis_aclk or negedge s02_axis_aresetn) begin
        if (!s02_axis_aresetn) begin
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tstrb_q  <= '0;
            hold_q     <= '0;
            load_q     <= 1'b0;
        end else begin
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tstrb_q  <= m_tstrb_d;
            hold_q     <= hold_d;
            load_q     <= load_d;
        end
    end

    assign s02_axis_tready   = s_tready_q;
    assign m02_axis_tvalid   = m_tvalid_q;
    assign m02_axis_tlast    = m_tlast_q;
    assign m02_axis_tstrb    = m_tstrb_q;
    assign m02_axis_rd_tdata = load_q ? fresh_data : hold_q;

endmodule

// File: tb/tb_axis_memory.sv
// Scoreboard bench for axis_memory: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_axis_memory;
    import axis_memory_pkg::*;

`ifdef AXIS_MEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef logic [DEFAULT_DATA_WIDTH+STRB_WIDTH:0] beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b1;
    logic  wr_en = 1'b0;
    addr_t wr_addr = '0;
    data_t wr_data = '0;
    strb_t wr_strb = '0;
    logic  s_tvalid = 1'b0;
    logic  s_tlast = 1'b0;
    logic  s_tready;
    logic  rd_en = 1'b0;
    addr_t rd_addr = '0;
    logic  m_tready = 1'b1;
    data_t m_data;
    strb_t m_strb;
    logic  m_tvalid;
    logic  m_tlast;

    int n_cmp = 0;
    int n_err = 0;
    beat_t exp_q[$];

    axis_memory #(
        .ADDR_WIDTH(DEFAULT_ADDR_WIDTH),
        .DATA_WIDTH(DEFAULT_DATA_WIDTH)
    ) dut (
        .s02_axis_aclk     (clk),
        .s02_axis_aresetn  (rst_n),
        .s02_axis_wr_en    (wr_en),
        .s02_axis_wr_addr  (wr_addr),
        .s02_axis_wr_tdata (wr_data),
        .s02_axis_tstrb    (wr_strb),
        .s02_axis_tvalid   (s_tvalid),
        .s02_axis_tlast    (s_tlast),
        .s02_axis_tready   (s_tready),
        .m02_axis_rd_en    (rd_en),
        .m02_axis_rd_addr  (rd_addr),
        .m02_axis_tready   (m_tready),
        .m02_axis_rd_tdata (m_data),
        .m02_axis_tstrb    (m_strb),
        .m02_axis_tvalid   (m_tvalid),
        .m02_axis_tlast    (m_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every beat that transfers on the next edge is popped and compared.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got data 0x%0h expected no beat", m_data);
            end else begin
                check("beat", 64'({m_data, m_strb, m_tlast}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input addr_t a, input data_t d, input strb_t s);
        wr_en = 1'b1; s_tvalid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        tick();
        wr_en = 1'b0; s_tvalid = 1'b0;
    endtask

    task automatic do_read(input addr_t a, input data_t d);
        rd_en = 1'b1; rd_addr = a;
        exp_q.push_back({d, 4'hF, 1'b1});
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset: low for 2 ns
        #1 rst_n = 1'b0;
        #1;
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast",  64'(m_tlast),  64'd0);
        check("rst_m_tstrb",  64'(m_strb),   64'd0);
        check("rst_m_tdata",  64'(m_data),   64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("s_tready_after_rst", 64'(s_tready), 64'd1);

        // Basic write then read
        do_write(12'h001, 32'h0000_0022, 4'hF);
        do_read(12'h001, 32'h0000_0022);
        tick();

        // Byte strobes
        do_write(12'h010, 32'hAABB_CCDD, 4'hF);
        do_write(12'h010, 32'h1122_3344, 4'b0101);
        do_read(12'h010, 32'hAA22_CC44);
        tick();

        // Non-firing write attempts, including an empty strobe
        do_write(12'h030, 32'h1234_5678, 4'hF);
        wr_en = 1'b1; s_tvalid = 1'b0; wr_addr = 12'h030; wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
        tick();
        wr_en = 1'b0; s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        do_write(12'h030, 32'h0, 4'h0);
        do_read(12'h030, 32'h1234_5678);
        tick();

        // Stall: output held, competing request refused, write elsewhere proceeds
        m_tready = 1'b0;
        do_read(12'h001, 32'h0000_0022);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; s_tvalid = 1'b1; wr_addr = 12'h040; wr_data = data_t'(i); wr_strb = 4'hF;
            rd_en = 1'b1; rd_addr = 12'h010;
            @(negedge clk);
            check("stall_tvalid", 64'(m_tvalid), 64'd1);
            check("stall_tdata", 64'(m_data), 64'h22);
            tick();
        end
        wr_en = 1'b0; s_tvalid = 1'b0; rd_en = 1'b0; m_tready = 1'b1;
        tick();
        @(negedge clk);
        check("idle_tvalid", 64'(m_tvalid), 64'd0);
        check("idle_tlast", 64'(m_tlast), 64'd0);
        check("idle_tdata_kept", 64'(m_data), 64'h22);
        do_read(12'h040, 32'h0000_0004);
        tick();

        // Back-to-back reads with rd_en held high
        rd_en = 1'b1;
        rd_addr = 12'h001; exp_q.push_back({32'h0000_0022, 4'hF, 1'b1}); tick();
        rd_addr = 12'h010; exp_q.push_back({32'hAA22_CC44, 4'hF, 1'b1}); tick();
        rd_addr = 12'h030; exp_q.push_back({32'h1234_5678, 4'hF, 1'b1}); tick();
        rd_en = 1'b0;
        tick();

        // Same-edge write/read collision, full and partial strobe
        do_write(12'h020, 32'h0000_0033, 4'hF);
        wr_en = 1'b1; s_tvalid = 1'b1; wr_addr = 12'h020; wr_data = 32'h0000_0055; wr_strb = 4'hF;
        do_read(12'h020, BYP ? 32'h0000_0055 : 32'h0000_0033);
        wr_en = 1'b1; s_tvalid = 1'b1; wr_addr = 12'h020; wr_data = 32'h0000_6600; wr_strb = 4'b0010;
        do_read(12'h020, BYP ? 32'h0000_6655 : 32'h0000_0055);
        wr_en = 1'b0; s_tvalid = 1'b0;
        do_read(12'h020, 32'h0000_6655);
        tick();

        // Reset during a stalled beat; a write attempted under reset must not land
        m_tready = 1'b0;
        rd_en = 1'b1; rd_addr = 12'h010;
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        check("inflight_tvalid", 64'(m_tvalid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_tdata",  64'(m_data),   64'd0);
        check("midrst_s_tready", 64'(s_tready), 64'd0);
        wr_en = 1'b1; s_tvalid = 1'b1; wr_addr = 12'h010; wr_data = 32'hDEAD_BEEF; wr_strb = 4'hF;
        tick();
        wr_en = 1'b0; s_tvalid = 1'b0;
        rst_n = 1'b1; m_tready = 1'b1;
        tick();
        check("s_tready_after_rst2", 64'(s_tready), 64'd1);
        do_read(12'h010, 32'hAA22_CC44);
        tick();
        tick();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
